raw_frame_sched: RTL and testbench



---
 rtl/raw_frame_sched_if.sv | 10 +
 rtl/raw_frame_sched.sv | 194 +++++++++++++++++++
 tb/tb_raw_frame_sched.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/raw_frame_sched_if.sv
// RAW8 sensor-style stream bundle: frame valid, line valid and pixel byte.
// The driver uses the master modport and the receiver uses the slave modport.
interface raw_frame_sched_if;
    logic       vs;
    logic       de;
    logic [7:0] data;

    modport master (output vs, de, data);
    modport slave  (input  vs, de, data);
endinterface

// File: rtl/raw_frame_sched.sv
// Frame scheduler between the RAW8 sensor stream and the demosaic stage: arm, align, forward, check, flush.
// Optional feature macro: FLUSH_LINE_EN (adds the blanking gap and the zero flush line after each frame).
module raw_frame_sched #(
    parameter int H_SIZE = 1920,
    parameter int V_SIZE = 1080,
    parameter int HBLANK = 16
) (
    input  logic                      I_clk,
    input  logic                      I_rst_n,
    input  logic                      I_start,
    input  logic                      I_continuous,
    input  logic                      I_abort,
    raw_frame_sched_if.slave          I_raw,
    raw_frame_sched_if.master         O_raw,
    output logic                      O_busy,
    output logic                      O_frame_done,
    output logic                      O_err_line,
    output logic                      O_err_frame,
    output logic [10:0]               O_line_cnt
);

    if (H_SIZE < 1 || H_SIZE > 16383 || V_SIZE < 1 || V_SIZE > 2047 || HBLANK < 1) begin : g_bad_params
        $error("raw_frame_sched: geometry parameters out of range");
    end

    localparam logic [13:0] H_LEN  = 14'(H_SIZE);
    localparam logic [10:0] V_LAST = 11'(V_SIZE - 1);
`ifdef FLUSH_LINE_EN
    localparam logic [13:0] GAP_LAST   = 14'(HBLANK - 1);
    localparam logic [13:0] FLUSH_LAST = 14'(H_SIZE - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_ACTIVE, S_BLANK, S_FLUSH, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        vs_d_q, de_d_q;
    logic [13:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
`ifdef FLUSH_LINE_EN
    logic [13:0] gap_cnt_q, gap_cnt_d;
`endif

    logic        o_vs_q, o_vs_d;
    logic        o_de_q, o_de_d;
    logic [7:0]  o_data_q, o_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_line_q, err_line_d;
    logic        err_frame_q, err_frame_d;

    logic vs_rise, vs_fall, de_fall, frame_complete;

    assign vs_rise        = !vs_d_q && I_raw.vs;
    assign vs_fall        = vs_d_q && !I_raw.vs;
    assign de_fall        = de_d_q && !I_raw.de;
    assign frame_complete = de_fall && (v_cnt_q == V_LAST);

    // State register
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
`ifdef FLUSH_LINE_EN
        gap_cnt_d = gap_cnt_q;
`endif
        if (I_abort) begin
            state_d = S_IDLE;
            h_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (I_start) state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (vs_rise) begin
                        state_d = S_ACTIVE;
                        h_cnt_d = '0;
                        v_cnt_d = '0;
                    end
                end
                S_ACTIVE: begin
                    if (I_raw.de && h_cnt_q != 14'h3fff) h_cnt_d = h_cnt_q + 14'd1;
                    if (de_fall) begin
                        h_cnt_d = '0;
                        v_cnt_d = v_cnt_q + 11'd1;
                    end
                    // A completed last line wins over a coincident vs fall.
                    if (frame_complete) begin
`ifdef FLUSH_LINE_EN
                        state_d   = S_BLANK;
                        gap_cnt_d = '0;
`else
                        state_d   = S_DONE;
`endif
                    end else if (vs_fall) begin
                        state_d = I_continuous ? S_ARMED : S_IDLE;
                    end
                end
`ifdef FLUSH_LINE_EN
                S_BLANK: begin
                    gap_cnt_d = gap_cnt_q + 14'd1;
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d   = S_FLUSH;
                        gap_cnt_d = '0;
                    end
                end
                S_FLUSH: begin
                    gap_cnt_d = gap_cnt_q + 14'd1;
                    if (gap_cnt_q == FLUSH_LAST) begin
                        state_d   = S_DONE;
                        gap_cnt_d = '0;
                    end
                end
`endif
                S_DONE: begin
                    state_d = I_continuous ? S_ARMED : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output logic: every output is registered from the upcoming state
    always_comb begin
        o_vs_d   = (state_d == S_ACTIVE) || (state_d == S_BLANK) || (state_d == S_FLUSH);
        o_de_d   = 1'b0;
        o_data_d = 8'd0;
        if (state_d == S_FLUSH) begin
            o_de_d = 1'b1;
        end else if (state_q == S_ACTIVE && state_d == S_ACTIVE && I_raw.de && h_cnt_q < H_LEN) begin
            o_de_d   = 1'b1;
            o_data_d = I_raw.data;
        end
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        err_line_d  = !I_abort && (state_q == S_ACTIVE) && de_fall && (h_cnt_q != H_LEN);
        err_frame_d = !I_abort && (state_q == S_ACTIVE) && vs_fall && !frame_complete;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            vs_d_q      <= 1'b0;
            de_d_q      <= 1'b0;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
`ifdef FLUSH_LINE_EN
            gap_cnt_q   <= '0;
`endif
            o_vs_q      <= 1'b0;
            o_de_q      <= 1'b0;
            o_data_q    <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_line_q  <= 1'b0;
            err_frame_q <= 1'b0;
        end else begin
            vs_d_q      <= I_raw.vs;
            de_d_q      <= I_raw.de;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
`ifdef FLUSH_LINE_EN
            gap_cnt_q   <= gap_cnt_d;
`endif
            o_vs_q      <= o_vs_d;
            o_de_q      <= o_de_d;
            o_data_q    <= o_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_line_q  <= err_line_d;
            err_frame_q <= err_frame_d;
        end
    end

    assign O_raw.vs     = o_vs_q;
    assign O_raw.de     = o_de_q;
    assign O_raw.data   = o_data_q;
    assign O_busy       = busy_q;
    assign O_frame_done = done_q;
    assign O_err_line   = err_line_q;
    assign O_err_frame  = err_frame_q;
    assign O_line_cnt   = v_cnt_q;

endmodule

// File: tb/tb_raw_frame_sched.sv
// Directed bench for raw_frame_sched with an 8x4 frame and a 3-cycle gap.
// Expectations adapt to FLUSH_LINE_EN so the same bench covers both builds.
module tb_raw_frame_sched;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int HB = 3;

    logic        clk;
    logic        rst_n;
    logic        start, cont, abort;
    logic        busy, done, err_line, err_frame;
    logic [10:0] line_cnt;
    int          n_vec;
    int          n_err;

    raw_frame_sched_if in_if ();
    raw_frame_sched_if out_if ();

    raw_frame_sched #(.H_SIZE(H), .V_SIZE(V), .HBLANK(HB)) dut (
        .I_clk        (clk),
        .I_rst_n      (rst_n),
        .I_start      (start),
        .I_continuous (cont),
        .I_abort      (abort),
        .I_raw        (in_if),
        .O_raw        (out_if),
        .O_busy       (busy),
        .O_frame_done (done),
        .O_err_line   (err_line),
        .O_err_frame  (err_frame),
        .O_line_cnt   (line_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one input cycle, then look at the outputs 1 time unit after the edge.
    task automatic step(input logic vs, input logic de, input logic [7:0] d);
        in_if.vs   = vs;
        in_if.de   = de;
        in_if.data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic vs);
        start = 1'b1;
        step(vs, 1'b0, 8'd0);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic rise(input bit fwd);
        step(1'b1, 1'b0, 8'd0);
        chk("rise_vs", 32'(out_if.vs), 32'(fwd));
        chk("rise_de", 32'(out_if.de), 32'd0);
        if (fwd) chk("rise_line_cnt", 32'(line_cnt), 32'd0);
    endtask

    task automatic line(input int len, input int base, input bit fwd, input int cnt_after);
        for (int p = 0; p < len; p++) begin
            step(1'b1, 1'b1, 8'(base + p));
            chk("pix_vs", 32'(out_if.vs), 32'(fwd));
            chk("pix_de", 32'(out_if.de), (fwd && p < H) ? 32'd1 : 32'd0);
            chk("pix_data", 32'(out_if.data), (fwd && p < H) ? 32'(8'(base + p)) : 32'd0);
            if (p == 0) chk("err_line_clear", 32'(err_line), 32'd0);
        end
        step(1'b1, 1'b0, 8'd0);
        chk("err_line", 32'(err_line), (fwd && len != H) ? 32'd1 : 32'd0);
        chk("line_cnt", 32'(line_cnt), 32'(cnt_after));
        chk("gap_data", 32'(out_if.data), 32'd0);
    endtask

    task automatic std_frame(input int seed);
        rise(1'b1);
        for (int l = 0; l < V; l++) line(H, seed + 16 * l, 1'b1, l + 1);
    endtask

    // End-of-frame sequence after the last line's falling edge has been applied.
    task automatic tail(input bit cont_exp);
`ifdef FLUSH_LINE_EN
        chk("blank_vs", 32'(out_if.vs), 32'd1);
        chk("blank_de", 32'(out_if.de), 32'd0);
        for (int i = 1; i < HB; i++) begin
            step(1'b0, 1'b0, 8'd0);
            chk("blank_vs", 32'(out_if.vs), 32'd1);
            chk("blank_de", 32'(out_if.de), 32'd0);
        end
        for (int i = 0; i < H; i++) begin
            step(1'b0, 1'b1, 8'hAA);
            chk("flush_vs", 32'(out_if.vs), 32'd1);
            chk("flush_de", 32'(out_if.de), 32'd1);
            chk("flush_data", 32'(out_if.data), 32'd0);
            chk("flush_no_done", 32'(done), 32'd0);
        end
        step(1'b0, 1'b0, 8'd0);
`endif
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_vs", 32'(out_if.vs), 32'd0);
        chk("done_de", 32'(out_if.de), 32'd0);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_line_cnt", 32'(line_cnt), 32'(V));
        step(1'b0, 1'b0, 8'd0);
        chk("done_single", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'(cont_exp));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        cont  = 1'b0;
        abort = 1'b0;
        in_if.vs = 1'b0;
        in_if.de = 1'b0;
        in_if.data = 8'd0;
        #1;
        chk("rst_vs", 32'(out_if.vs), 32'd0);
        chk("rst_de", 32'(out_if.de), 32'd0);
        chk("rst_data", 32'(out_if.data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_errs", 32'({err_line, err_frame}), 32'd0);
        chk("rst_line_cnt", 32'(line_cnt), 32'd0);
        #20 rst_n = 1'b1;
        step(1'b0, 1'b0, 8'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Single frame, single shot
        pulse_start(1'b0);
        std_frame(1);
        tail(1'b0);

        // Arm while vs already high: that frame is blocked, the next is forwarded
        step(1'b1, 1'b0, 8'd0);
        pulse_start(1'b1);
        for (int l = 0; l < V; l++) line(H, 8'h80 + 16 * l, 1'b0, V);
        step(1'b0, 1'b0, 8'd0);
        chk("blocked_busy", 32'(busy), 32'd1);
        std_frame(2);
        tail(1'b0);

        // Short and long lines
        pulse_start(1'b0);
        rise(1'b1);
        line(8, 8'h10, 1'b1, 1);
        line(6, 8'h20, 1'b1, 2);
        line(10, 8'h30, 1'b1, 3);
        line(8, 8'h40, 1'b1, 4);
        tail(1'b0);

        // Truncated frame in continuous mode, then a good frame
        cont = 1'b1;
        pulse_start(1'b0);
        rise(1'b1);
        line(H, 8'h50, 1'b1, 1);
        line(H, 8'h60, 1'b1, 2);
        step(1'b0, 1'b0, 8'd0);
        chk("trunc_err_frame", 32'(err_frame), 32'd1);
        chk("trunc_vs", 32'(out_if.vs), 32'd0);
        chk("trunc_no_done", 32'(done), 32'd0);
        chk("trunc_busy", 32'(busy), 32'd1);
        step(1'b0, 1'b0, 8'd0);
        chk("trunc_err_single", 32'(err_frame), 32'd0);
        cont = 1'b0;
        std_frame(3);
        tail(1'b0);

        // Three back-to-back continuous frames, then an abort in the fourth
        cont = 1'b1;
        pulse_start(1'b0);
        std_frame(4);
        tail(1'b1);
        std_frame(5);
        tail(1'b1);
        std_frame(6);
        tail(1'b1);
        std_frame(7);
`ifdef FLUSH_LINE_EN
        for (int i = 1; i < HB; i++) step(1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'd0);
        chk("pre_abort_flush_de", 32'(out_if.de), 32'd1);
        abort = 1'b1;
        step(1'b0, 1'b0, 8'd0);
`else
        abort = 1'b1;
        step(1'b0, 1'b0, 8'd0);
`endif
        abort = 1'b0;
        chk("abort_vs", 32'(out_if.vs), 32'd0);
        chk("abort_de", 32'(out_if.de), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_no_done", 32'(done), 32'd0);
        step(1'b0, 1'b0, 8'd0);
        chk("abort_still_no_done", 32'(done), 32'd0);
        chk("abort_stays_idle", 32'(busy), 32'd0);
        cont = 1'b0;

        // Asynchronous reset in the middle of a line
        pulse_start(1'b0);
        rise(1'b1);
        step(1'b1, 1'b1, 8'h77);
        step(1'b1, 1'b1, 8'h78);
        chk("pre_rst_de", 32'(out_if.de), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_vs", 32'(out_if.vs), 32'd0);
        chk("async_rst_de", 32'(out_if.de), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_line_cnt", 32'(line_cnt), 32'd0);
        #4 rst_n = 1'b1;
        step(1'b0, 1'b0, 8'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
